divmmc_memctl: RTL and testbench

- Downstream consumer of the DivMMC mapping outputs (div_map, div_ram, div_page, div_ramwr_mask).
- Translates Z80 accesses to 0000-3FFF, while DivMMC is mapped, into physical SRAM page addresses and timed CE/OE/WE strobes for the shared 512K SRAM.
- Page selection is latched per memory cycle, so mid-cycle mapping changes never glitch the SRAM address.
- Write pulses are sequenced by a small FSM on clk28.

---
 rtl/divmmc_memctl_pkg.sv | 22 ++
 rtl/cpu_bus.sv | 10 +
 rtl/divmmc_memctl.sv | 144 ++++++++++++++
 tb/tb_divmmc_memctl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divmmc_memctl_pkg.sv
// Shared types and helpers for the DivMMC SRAM memory controller.
package divmmc_memctl_pkg;

    localparam int PAGE_W = 6;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WSET = 3'd2,
        WPUL = 3'd3,
        WHLD = 3'd4,
        WBLK = 3'd5,
        WEND = 3'd6
    } memctl_state_t;

    // DivMMC RAM pages live in the 16-page window selected by the top bits of the base.
    function automatic logic [PAGE_W-1:0] ram_page(input logic [PAGE_W-1:0] base,
                                                   input logic [3:0]        page);
        return {base[5:4], page};
    endfunction

endpackage

// File: rtl/cpu_bus.sv
// Z80 CPU bus signals as seen by memory-side consumers.
interface cpu_bus;
    logic [15:0] a;
    logic        mreq;
    logic        rd;
    logic        wr;
    logic        rfsh;

    modport mem (input a, input mreq, input rd, input wr, input rfsh);
endinterface

// File: rtl/divmmc_memctl.sv
// DivMMC SRAM controller: page latch plus CE/OE/WE sequencing on clk28.
// Optional DIVMMC_ROMWR_EN makes unmasked ROM-area writes reach the SRAM (ROM update).
module divmmc_memctl
    import divmmc_memctl_pkg::*;
#(
    parameter logic [PAGE_W-1:0] RAM_BASE     = 6'h20,
    parameter logic [PAGE_W-1:0] ROM_PAGE     = 6'h1F,
    parameter int                WR_SETUP     = 2,
    parameter int                WR_PULSE_MAX = 6
) (
    input  logic              rst_n,
    input  logic              clk28,
    cpu_bus.mem               bus,
    input  logic              div_map,
    input  logic              div_ram,
    input  logic [3:0]        div_page,
    input  logic              div_ramwr_mask,
    output logic              active,
    output logic [PAGE_W-1:0] ra,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam logic [2:0] SETUP_LAST = 3'(WR_SETUP - 1);
    localparam logic [2:0] PULSE_LAST = 3'(WR_PULSE_MAX - 1);

    memctl_state_t     state_r;
    logic [2:0]        cnt_r;
    logic              hit_s;
    logic              writable_s;
    logic [PAGE_W-1:0] page_s;
    logic              unused_a_s;

    assign unused_a_s = ^bus.a[12:0];

    // Access decode: hit detection, physical page mux and write permission.
    always_comb begin
        hit_s = bus.mreq && !bus.rfsh && (bus.rd || bus.wr) &&
                (bus.a[15:14] == 2'b00) && div_map;
        if (!div_ram) begin
            page_s = ROM_PAGE;
        end else if (bus.a[13]) begin
            page_s = ram_page(RAM_BASE, div_page);
        end else begin
            page_s = ram_page(RAM_BASE, 4'h3);
        end
`ifdef DIVMMC_ROMWR_EN
        writable_s = !div_ramwr_mask;
`else
        writable_s = div_ram && !div_ramwr_mask;
`endif
    end

    // Cycle FSM; ra is latched only when leaving IDLE so remaps cannot glitch the address.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= 3'd0;
            active    <= 1'b0;
            ra        <= '0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r <= 3'd0;
                    if (hit_s && bus.rd) begin
                        state_r   <= RD;
                        ra        <= page_s;
                        active    <= 1'b1;
                        sram_ce_n <= 1'b0;
                        sram_oe_n <= 1'b0;
                    end else if (hit_s && bus.wr && writable_s) begin
                        state_r   <= WSET;
                        ra        <= page_s;
                        active    <= 1'b1;
                        sram_ce_n <= 1'b0;
                    end else if (hit_s && bus.wr) begin
                        state_r   <= WBLK;
                        ra        <= page_s;
                        active    <= 1'b1;
                    end else begin
                        active    <= 1'b0;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                    end
                end
                RD: begin
                    if (!bus.mreq) begin
                        state_r   <= IDLE;
                        active    <= 1'b0;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                    end
                end
                WSET: begin
                    if (!bus.mreq || !bus.wr) begin
                        state_r   <= IDLE;
                        active    <= 1'b0;
                        sram_ce_n <= 1'b1;
                        cnt_r     <= 3'd0;
                    end else if (cnt_r == SETUP_LAST) begin
                        state_r   <= WPUL;
                        sram_we_n <= 1'b0;
                        cnt_r     <= 3'd0;
                    end else begin
                        cnt_r <= cnt_r + 3'd1;
                    end
                end
                WPUL: begin
                    if (!bus.wr || cnt_r == PULSE_LAST) begin
                        state_r   <= WHLD;
                        sram_we_n <= 1'b1;
                        cnt_r     <= 3'd0;
                    end else begin
                        cnt_r <= cnt_r + 3'd1;
                    end
                end
                WHLD: begin
                    state_r   <= WEND;
                    sram_ce_n <= 1'b1;
                end
                WBLK, WEND: begin
                    if (!bus.mreq) begin
                        state_r <= IDLE;
                        active  <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= 3'd0;
                    active    <= 1'b0;
                    sram_ce_n <= 1'b1;
                    sram_oe_n <= 1'b1;
                    sram_we_n <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divmmc_memctl.sv
// Directed testbench for divmmc_memctl; expected strobe sequences are hand-derived.
module tb_divmmc_memctl;

    logic       clk28 = 1'b0;
    logic       rst_n;
    logic       div_map;
    logic       div_ram;
    logic [3:0] div_page;
    logic       div_ramwr_mask;
    logic       active;
    logic [5:0] ra;
    logic       sram_ce_n;
    logic       sram_oe_n;
    logic       sram_we_n;

    int errors = 0;
    int checks = 0;

    cpu_bus bus_if ();

    divmmc_memctl dut (
        .rst_n          (rst_n),
        .clk28          (clk28),
        .bus            (bus_if),
        .div_map        (div_map),
        .div_ram        (div_ram),
        .div_page       (div_page),
        .div_ramwr_mask (div_ramwr_mask),
        .active         (active),
        .ra             (ra),
        .sram_ce_n      (sram_ce_n),
        .sram_oe_n      (sram_oe_n),
        .sram_we_n      (sram_we_n)
    );

    always #18 clk28 = ~clk28;

    // {active, ce_n, oe_n, we_n}
    wire [3:0] st = {active, sram_ce_n, sram_oe_n, sram_we_n};

    task automatic tick();
        @(posedge clk28);
        #1;
    endtask

    task automatic bus_idle();
        bus_if.mreq = 1'b0;
        bus_if.rd   = 1'b0;
        bus_if.wr   = 1'b0;
        bus_if.rfsh = 1'b0;
        bus_if.a    = 16'h0000;
    endtask

    task automatic bus_start(input logic [15:0] addr, input logic is_wr);
        bus_if.a    = addr;
        bus_if.mreq = 1'b1;
        bus_if.rd   = !is_wr;
        bus_if.wr   = is_wr;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_idle();
        div_map = 1'b0; div_ram = 1'b0; div_page = 4'h0; div_ramwr_mask = 1'b0;
        tick(); tick();
        checks++;
        if (st !== 4'b0111) begin errors++; $display("FAIL reset_strobes: got %b want 0111", st); end
        checks++;
        if (ra !== 6'h00) begin errors++; $display("FAIL reset_ra: got %h want 00", ra); end
        rst_n = 1'b1;
        tick();
        checks++;
        if (st !== 4'b0111) begin errors++; $display("FAIL post_reset_idle: got %b want 0111", st); end
    endtask

    task automatic test_read();
        div_map = 1'b1; div_ram = 1'b1; div_page = 4'h5; div_ramwr_mask = 1'b0;
        bus_start(16'h2000, 1'b0);
        #1;
        checks++;
        if (sram_ce_n !== 1'b1) begin errors++; $display("FAIL read_pre_edge_ce: got %b want 1", sram_ce_n); end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (st !== 4'b1001 || ra !== 6'h25) begin
                errors++; $display("FAIL read_c%0d: got st=%b ra=%h want st=1001 ra=25", i, st, ra);
            end
        end
        bus_idle();
        tick();
        checks++;
        if (st !== 4'b0111) begin errors++; $display("FAIL read_end: got %b want 0111", st); end
    endtask

    task automatic test_write_full();
        logic [3:0] exp [0:8];
        int we_low;
        exp = '{4'b1011, 4'b1011, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1011, 4'b1111, 4'b0111};
        we_low = 0;
        div_page = 4'h2; div_ram = 1'b1; div_ramwr_mask = 1'b0;
        bus_start(16'h3000, 1'b1);
        for (int i = 0; i < 9; i++) begin
            tick();
            if (sram_we_n === 1'b0) we_low++;
            checks++;
            if (st !== exp[i]) begin errors++; $display("FAIL write_c%0d: got %b want %b", i, st, exp[i]); end
            if (i == 5) bus_idle();
        end
        checks++;
        if (we_low != 4) begin errors++; $display("FAIL write_we_len: got %0d want 4", we_low); end
        checks++;
        if (ra !== 6'h22) begin errors++; $display("FAIL write_ra: got %h want 22", ra); end
    endtask

    task automatic test_write_protect();
        div_ram = 1'b1; div_ramwr_mask = 1'b1;
        bus_start(16'h1000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (st !== ((i < 4) ? 4'b1111 : 4'b0111)) begin
                errors++; $display("FAIL wprot_mask_c%0d: got %b want %b", i, st, (i < 4) ? 4'b1111 : 4'b0111);
            end
            if (i == 3) bus_idle();
        end
        div_ram = 1'b0; div_ramwr_mask = 1'b0;
        bus_start(16'h0500, 1'b1);
`ifdef DIVMMC_ROMWR_EN
        begin
            logic [3:0] exp [0:5];
            exp = '{4'b1011, 4'b1011, 4'b1010, 4'b1011, 4'b1111, 4'b0111};
            for (int i = 0; i < 6; i++) begin
                tick();
                checks++;
                if (st !== exp[i]) begin errors++; $display("FAIL romwr_c%0d: got %b want %b", i, st, exp[i]); end
                if (i == 2) bus_idle();
            end
        end
`else
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (st !== ((i < 4) ? 4'b1111 : 4'b0111)) begin
                errors++; $display("FAIL wprot_rom_c%0d: got %b want %b", i, st, (i < 4) ? 4'b1111 : 4'b0111);
            end
            if (i == 3) bus_idle();
        end
`endif
        checks++;
        if (ra !== 6'h1F) begin errors++; $display("FAIL wprot_rom_ra: got %h want 1f", ra); end
    endtask

    task automatic test_glitch();
        div_ram = 1'b1; div_ramwr_mask = 1'b0; div_page = 4'h3;
        bus_start(16'h2000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (ra !== 6'h23 || active !== 1'b1) begin
                errors++; $display("FAIL glitch_hold_c%0d: got ra=%h act=%b want ra=23 act=1", i, ra, active);
            end
            if (i == 1) div_page = 4'h7;
        end
        bus_idle();
        tick();
        checks++;
        if (st !== 4'b0111 || ra !== 6'h23) begin
            errors++; $display("FAIL glitch_idle: got st=%b ra=%h want st=0111 ra=23", st, ra);
        end
        bus_start(16'h2000, 1'b0);
        tick();
        checks++;
        if (st !== 4'b1001 || ra !== 6'h27) begin
            errors++; $display("FAIL glitch_next: got st=%b ra=%h want st=1001 ra=27", st, ra);
        end
        bus_idle();
        tick();
    endtask

    task automatic test_abort();
        div_page = 4'h1;
        bus_start(16'h2000, 1'b1);
        tick();
        checks++;
        if (st !== 4'b1011) begin errors++; $display("FAIL abort_wset: got %b want 1011", st); end
        bus_idle();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (st !== 4'b0111) begin errors++; $display("FAIL abort_c%0d: got %b want 0111", i, st); end
        end
    endtask

    task automatic test_long_pulse();
        int we_low;
        we_low = 0;
        bus_start(16'h2000, 1'b1);
        for (int i = 0; i < 22; i++) begin
            tick();
            if (sram_we_n === 1'b0) we_low++;
            if (i == 8) begin
                checks++;
                if (st !== 4'b1011) begin errors++; $display("FAIL long_whld: got %b want 1011", st); end
            end
            if (i == 9) begin
                checks++;
                if (st !== 4'b1111) begin errors++; $display("FAIL long_wend: got %b want 1111", st); end
            end
            if (i == 19) bus_idle();
        end
        checks++;
        if (we_low != 6) begin errors++; $display("FAIL long_we_len: got %0d want 6", we_low); end
        checks++;
        if (st !== 4'b0111) begin errors++; $display("FAIL long_idle: got %b want 0111", st); end
    endtask

    task automatic test_no_hit();
        bus_start(16'h0000, 1'b0);
        bus_if.rfsh = 1'b1;
        tick(); tick();
        checks++;
        if (st !== 4'b0111) begin errors++; $display("FAIL nohit_rfsh: got %b want 0111", st); end
        bus_idle();
        tick();
        bus_start(16'h4000, 1'b0);
        tick(); tick();
        checks++;
        if (st !== 4'b0111) begin errors++; $display("FAIL nohit_a4000: got %b want 0111", st); end
        bus_idle();
        tick();
        div_map = 1'b0;
        bus_start(16'h2000, 1'b1);
        tick(); tick();
        checks++;
        if (st !== 4'b0111) begin errors++; $display("FAIL nohit_unmapped: got %b want 0111", st); end
        bus_idle();
        div_map = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_write();
        bus_start(16'h2000, 1'b1);
        tick(); tick(); tick(); tick();
        checks++;
        if (st !== 4'b1010) begin errors++; $display("FAIL rstw_in_pulse: got %b want 1010", st); end
        rst_n = 1'b0;
        #2;
        checks++;
        if (sram_we_n !== 1'b1 || sram_ce_n !== 1'b1 || active !== 1'b0) begin
            errors++; $display("FAIL rstw_async: got st=%b want 0111", st);
        end
        tick();
        bus_idle();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (st !== 4'b0111) begin errors++; $display("FAIL rstw_after_c%0d: got %b want 0111", i, st); end
        end
        bus_start(16'h2000, 1'b0);
        tick();
        checks++;
        if (st !== 4'b1001) begin errors++; $display("FAIL rstw_idle_read: got %b want 1001", st); end
        bus_idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_full();
        test_write_protect();
        test_glitch();
        test_abort();
        test_long_pulse();
        test_no_hit();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
